// File: rtl/camera_line_packer.sv
// -----------------------------------------------------------------------------
// camera_line_packer
//
// Packs a 16-bit camera pixel stream into 64-bit little-endian words for the
// camera FIFO, one line at a time, and reports the byte count and error status
// of every completed line.
//
// Parameters
//   MAX_WORDS        : maximum number of 64-bit words stored per line
//
// Ports
//   clk              : system clock, rising edge
//   rst_n            : synchronous active-low reset
//   en               : block enable; low acts as a soft reset (ovf_sticky kept)
//   fval             : frame valid
//   lval             : line valid
//   dval             : pixel qualifier
//   pix[15:0]        : pixel data
//   fifo_din[63:0]   : packed word to the camera FIFO
//   fifo_wr_en       : one-cycle FIFO write strobe
//   fifo_full        : camera FIFO full
//   camer_tatal_data : byte count of the last completed line
//   linedone         : one-cycle pulse at line completion
//   line_err         : last completed line was overflowed or truncated
//   ovf_sticky       : a word was ever dropped on a full FIFO (reset clears)
//
// Build option
//   CAMERA_TEST_PATTERN_EN : when defined, every accepted pixel is replaced by
//                            a per-line 16-bit counter starting at zero.
// -----------------------------------------------------------------------------
module camera_line_packer #(
    parameter int MAX_WORDS = 8191
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        fval,
    input  logic        lval,
    input  logic        dval,
    input  logic [15:0] pix,
    output logic [63:0] fifo_din,
    output logic        fifo_wr_en,
    input  logic        fifo_full,
    output logic [15:0] camer_tatal_data,
    output logic        linedone,
    output logic        line_err,
    output logic        ovf_sticky
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LINE = 3'd1,
        IN_LINE   = 3'd2,
        FLUSH     = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [12:0] MAX_CNT = 13'(MAX_WORDS);

    state_t      state;
    logic        lval_d;
    logic [47:0] pack;          // lanes 0..2 of the word being assembled
    logic [1:0]  lane;          // next free lane
    logic [12:0] word_count;
    logic        line_err_acc;  // error seen so far on the current line
    logic        pix_seen;      // at least one pixel accepted on this line
    logic        frame_end;     // fval fell while the line was open
    logic        next_line;     // lval rose during FLUSH

`ifdef CAMERA_TEST_PATTERN_EN
    logic [15:0] tp_cnt;
`endif

    logic        lval_rise;
    logic        accept;
    logic        at_max;
    logic        store;
    logic [15:0] pix_sel;
    logic        flush_write;
    logic        flush_drop;
    logic [12:0] count_final;
    logic        err_final;
    logic        line_start;

    always_comb begin
        lval_rise   = lval & ~lval_d;
        accept      = (state == IN_LINE) && lval && dval;
        at_max      = (word_count >= MAX_CNT);
        store       = accept && !at_max;
`ifdef CAMERA_TEST_PATTERN_EN
        pix_sel     = tp_cnt;
`else
        pix_sel     = pix;
`endif
        // Partial word handling at the end of a line
        flush_write = (state == FLUSH) && (lane != 2'd0) && !fifo_full;
        flush_drop  = (state == FLUSH) && (lane != 2'd0) && fifo_full;
        count_final = word_count + {12'd0, flush_write};
        err_final   = line_err_acc | flush_drop;
        // A new line opens either from WAIT_LINE or straight out of DONE
        line_start  = ((state == WAIT_LINE) && fval && lval_rise) ||
                      ((state == DONE) && fval && !frame_end &&
                       (next_line || lval_rise));
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            state            <= IDLE;
            lval_d           <= 1'b0;
            pack             <= '0;
            lane             <= 2'd0;
            word_count       <= '0;
            line_err_acc     <= 1'b0;
            pix_seen         <= 1'b0;
            frame_end        <= 1'b0;
            next_line        <= 1'b0;
            fifo_din         <= '0;
            fifo_wr_en       <= 1'b0;
            linedone         <= 1'b0;
            camer_tatal_data <= '0;
            line_err         <= 1'b0;
`ifdef CAMERA_TEST_PATTERN_EN
            tp_cnt           <= '0;
`endif
            // Only a real reset clears the sticky overflow flag
            if (!rst_n) begin
                ovf_sticky <= 1'b0;
            end
        end else begin
            lval_d     <= lval;
            fifo_wr_en <= 1'b0;
            linedone   <= 1'b0;

            case (state)
                IDLE: begin
                    if (fval) begin
                        state <= WAIT_LINE;
                    end
                end

                WAIT_LINE: begin
                    if (!fval) begin
                        state <= IDLE;
                    end else if (lval_rise) begin
                        state <= IN_LINE;
                    end
                end

                IN_LINE: begin
                    if (store) begin
                        pix_seen <= 1'b1;
`ifdef CAMERA_TEST_PATTERN_EN
                        tp_cnt   <= tp_cnt + 16'd1;
`endif
                        if (lane == 2'd3) begin
                            // Fourth pixel completes the word
                            lane <= 2'd0;
                            pack <= '0;
                            if (fifo_full) begin
                                ovf_sticky   <= 1'b1;
                                line_err_acc <= 1'b1;
                            end else begin
                                fifo_din   <= {pix_sel, pack};
                                fifo_wr_en <= 1'b1;
                                word_count <= word_count + 13'd1;
                            end
                        end else begin
                            case (lane)
                                2'd0:    pack[15:0]  <= pix_sel;
                                2'd1:    pack[31:16] <= pix_sel;
                                default: pack[47:32] <= pix_sel;
                            endcase
                            lane <= lane + 2'd1;
                        end
                    end else if (accept) begin
                        // Line already holds MAX_WORDS: pixel is truncated
                        pix_seen     <= 1'b1;
                        line_err_acc <= 1'b1;
                    end

                    if (!fval) begin
                        frame_end <= 1'b1;
                        state     <= FLUSH;
                    end else if (!lval) begin
                        state     <= FLUSH;
                    end
                end

                FLUSH: begin
                    // Unused upper lanes are already zero since pack is
                    // cleared after every completed word
                    if (flush_write) begin
                        fifo_din   <= {16'd0, pack};
                        fifo_wr_en <= 1'b1;
                    end
                    if (flush_drop) begin
                        ovf_sticky <= 1'b1;
                    end
                    word_count <= count_final;
                    lane       <= 2'd0;
                    pack       <= '0;
                    // Status registers change here so they are visible
                    // during DONE together with the linedone pulse
                    if (pix_seen) begin
                        camer_tatal_data <= {count_final, 3'b000};
                        line_err         <= err_final;
                        linedone         <= 1'b1;
                    end
                    if (lval_rise) begin
                        next_line <= 1'b1;
                    end
                    state <= DONE;
                end

                DONE: begin
                    if (!fval || frame_end) begin
                        state <= IDLE;
                    end else if (next_line || lval_rise) begin
                        state <= IN_LINE;
                    end else begin
                        state <= WAIT_LINE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            if (line_start) begin
                pack         <= '0;
                lane         <= 2'd0;
                word_count   <= '0;
                line_err_acc <= 1'b0;
                pix_seen     <= 1'b0;
                frame_end    <= 1'b0;
                next_line    <= 1'b0;
`ifdef CAMERA_TEST_PATTERN_EN
                tp_cnt       <= '0;
`endif
            end
        end
    end

endmodule
